// File: rtl/vs_codec_responder_if.sv
// Serial bus between the MP3 SPI master and the VS10xx-style responder:
// SCI/SDI selects, serial clock and data, hardware reset, read data and DREQ.
interface vs_codec_responder_if;
   logic i_XCS;
   logic i_XDCS;
   logic i_SCK;
   logic i_SI;
   logic i_XRST;
   logic o_SO;
   logic o_DREQ;

   modport master (
      output i_XCS, i_XDCS, i_SCK, i_SI, i_XRST,
      input  o_SO, o_DREQ
   );

   modport slave (
      input  i_XCS, i_XDCS, i_SCK, i_SI, i_XRST,
      output o_SO, o_DREQ
   );
endinterface

// File: rtl/vs_codec_responder.sv
// Responder model of a VS10xx decoder serial side: SCI register file with
// read/write frames, SDI byte FIFO drained at a fixed rate, and DREQ flow control.
module vs_codec_responder #(
   parameter int FIFO_DEPTH      = 64,
   parameter int DREQ_FREE       = 32,
   parameter int DRAIN_DIV       = 200,
   parameter int SOFT_RST_CYCLES = 100
) (
   input  logic                          clk,
   input  logic                          rst,
   vs_codec_responder_if.slave           bus,
   output logic                          o_sci_wr,
   output logic [3:0]                    o_sci_addr,
   output logic [15:0]                   o_sci_data,
   output logic [15:0]                   o_mode,
   output logic [15:0]                   o_vol,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic [31:0]                   o_sdi_byte_cnt,
   output logic                          o_err
);

   localparam int LW  = $clog2(FIFO_DEPTH) + 1;
   localparam int DCW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam int HCW = $clog2(SOFT_RST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPC,
      S_ADDR,
      S_DATA_WR,
      S_DATA_RD,
      S_DONE
   } sci_state_t;

   sci_state_t state, state_nxt;

   logic [4:0]     sync1, sync2;
   logic           xcs_s, xdcs_s, sck_s, si_s, xrst_s;
   logic           sck_d, xcs_d, xdcs_d;
   logic           core_rst;
   logic           sck_rise, sck_fall, xcs_fall, xcs_rise;
   logic           sci_bit, sdi_bit, conflict;

   logic [5:0]     bit_cnt;
   logic [14:0]    sci_sr;
   logic [15:0]    sci_in;
   logic [7:0]     opcode;
   logic [7:0]     addr_q;
   logic [15:0]    rd_sr;
   logic           so;
   logic [15:0]    regs [16];
   logic           bad_op, wr_fire, rd_load, soft_rst;
   logic [HCW-1:0] hold_cnt;

   logic [2:0]     sdi_cnt;
   logic [LW-1:0]  level;
   logic [DCW-1:0] drain_cnt;
   logic           push, full, push_ok, pop;
   logic           dreq;

   // Two-flop synchronizers plus one history flop for edge detection; only the
   // external reset clears them so they keep tracking the pins during XRST.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 5'b10011;
         sync2  <= 5'b10011;
         sck_d  <= 1'b0;
         xcs_d  <= 1'b1;
         xdcs_d <= 1'b1;
      end else begin
         sync1  <= {bus.i_XRST, bus.i_SI, bus.i_SCK, bus.i_XDCS, bus.i_XCS};
         sync2  <= sync1;
         sck_d  <= sck_s;
         xcs_d  <= xcs_s;
         xdcs_d <= xdcs_s;
      end
   end

   assign xcs_s    = sync2[0];
   assign xdcs_s   = sync2[1];
   assign sck_s    = sync2[2];
   assign si_s     = sync2[3];
   assign xrst_s   = sync2[4];
   assign core_rst = rst | ~xrst_s;

   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign xcs_fall = ~xcs_s & xcs_d;
   assign xcs_rise = xcs_s & ~xcs_d;
   assign conflict = ~xcs_s & ~xdcs_s;
   assign sci_bit  = sck_rise & ~xcs_s & xdcs_s;
   assign sdi_bit  = sck_rise & ~xdcs_s & xcs_s;
   assign sci_in   = {sci_sr, si_s};

   always_ff @(posedge clk) begin
      if (core_rst) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Frame decode: bit_cnt holds the bits already seen, so the bit completing
   // the opcode/address/data field arrives while bit_cnt is 7/15/31.
   always_comb begin
      state_nxt = state;
      bad_op    = 1'b0;
      wr_fire   = 1'b0;
      rd_load   = 1'b0;
      case (state)
         S_IDLE:    if (xcs_fall) state_nxt = S_OPC;
         S_OPC:     if (sci_bit && bit_cnt == 6'd7) state_nxt = S_ADDR;
         S_ADDR: begin
            if (sci_bit && bit_cnt == 6'd15) begin
               if (opcode == 8'h02) begin
                  state_nxt = S_DATA_WR;
               end else if (opcode == 8'h03) begin
                  state_nxt = S_DATA_RD;
                  rd_load   = 1'b1;
               end else begin
                  state_nxt = S_DONE;
                  bad_op    = 1'b1;
               end
            end
         end
         S_DATA_WR: begin
            if (sci_bit && bit_cnt == 6'd31) begin
               state_nxt = S_DONE;
               wr_fire   = 1'b1;
            end
         end
         S_DATA_RD: if (sci_bit && bit_cnt == 6'd31) state_nxt = S_DONE;
         default:   state_nxt = state;
      endcase
      if (xcs_rise) state_nxt = S_IDLE;
   end

   assign soft_rst = wr_fire && (addr_q == 8'h00) && sci_in[2];

   always_ff @(posedge clk) begin
      if (core_rst) begin
         bit_cnt    <= '0;
         sci_sr     <= '0;
         opcode     <= '0;
         addr_q     <= '0;
         rd_sr      <= '0;
         so         <= 1'b0;
         o_sci_wr   <= 1'b0;
         o_sci_addr <= '0;
         o_sci_data <= '0;
         hold_cnt   <= '0;
         for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? 16'h0800 : 16'h0000;
      end else begin
         o_sci_wr <= 1'b0;
         if (xcs_fall)
            bit_cnt <= '0;
         else if (sci_bit && bit_cnt != 6'd63)
            bit_cnt <= bit_cnt + 6'd1;
         if (sci_bit) sci_sr <= sci_in[14:0];
         if (state == S_OPC && sci_bit && bit_cnt == 6'd7) opcode <= sci_in[7:0];
         if (state == S_ADDR && sci_bit && bit_cnt == 6'd15) addr_q <= sci_in[7:0];

         if (state != S_DATA_RD) begin
            so <= 1'b0;
         end else if (sck_fall) begin
            so    <= rd_sr[15];
            rd_sr <= {rd_sr[14:0], 1'b0};
         end
         if (rd_load) rd_sr <= (sci_in[7:4] == 4'h0) ? regs[sci_in[3:0]] : 16'h0000;

         // The soft-reset bit of SCI_MODE is a command, so it is never stored.
         if (wr_fire && addr_q[7:4] == 4'h0) begin
            regs[addr_q[3:0]] <= (addr_q[3:0] == 4'h0) ? (sci_in & 16'hFFFB) : sci_in;
            o_sci_wr   <= 1'b1;
            o_sci_addr <= addr_q[3:0];
            o_sci_data <= sci_in;
         end

         if (soft_rst)
            hold_cnt <= HCW'(SOFT_RST_CYCLES);
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
      end
   end

   // The decoder model only consumes bytes, so the FIFO tracks occupancy alone.
   assign push    = sdi_bit && (sdi_cnt == 3'd7);
   assign full    = (level == LW'(FIFO_DEPTH));
   assign push_ok = push && !full;
   assign pop     = (drain_cnt == DCW'(DRAIN_DIV - 1)) && (level != '0);

   always_ff @(posedge clk) begin
      if (core_rst) begin
         sdi_cnt        <= '0;
         level          <= '0;
         drain_cnt      <= '0;
         o_sdi_byte_cnt <= '0;
      end else begin
         if (xdcs_s)
            sdi_cnt <= '0;
         else if (sdi_bit)
            sdi_cnt <= sdi_cnt + 3'd1;

         if (soft_rst) begin
            level     <= '0;
            drain_cnt <= '0;
         end else begin
            level <= level + LW'(push_ok) - LW'(pop);
            if (level == '0 || drain_cnt == DCW'(DRAIN_DIV - 1))
               drain_cnt <= '0;
            else
               drain_cnt <= drain_cnt + 1'b1;
         end

         if (push_ok) o_sdi_byte_cnt <= o_sdi_byte_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (core_rst) begin
         o_err <= 1'b0;
         dreq  <= 1'b0;
      end else begin
         if (bad_op || (wr_fire && addr_q[7:4] != 4'h0) || (push && full) || conflict)
            o_err <= 1'b1;
         dreq <= ((LW'(FIFO_DEPTH) - level) >= LW'(DREQ_FREE)) && (hold_cnt == '0);
      end
   end

   assign bus.o_SO     = so;
   assign bus.o_DREQ   = dreq;
   assign o_mode       = regs[0];
   assign o_vol        = regs[11];
   assign o_fifo_level = level;

endmodule

// File: tb/tb_vs_codec_responder.sv
// Directed bench for vs_codec_responder: table of SCI write/read-back vectors
// plus hand-written sequences for soft reset, SDI flow control, overflow and errors.
module tb_vs_codec_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_sci_wr;
   logic [3:0]  o_sci_addr;
   logic [15:0] o_sci_data;
   logic [15:0] o_mode;
   logic [15:0] o_vol;
   logic [6:0]  o_fifo_level;
   logic [31:0] o_sdi_byte_cnt;
   logic        o_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int last_wr_cyc = 0;

   vs_codec_responder_if bus ();

   vs_codec_responder #(
      .FIFO_DEPTH(64),
      .DREQ_FREE(32),
      .DRAIN_DIV(20000),
      .SOFT_RST_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .o_sci_wr(o_sci_wr),
      .o_sci_addr(o_sci_addr),
      .o_sci_data(o_sci_data),
      .o_mode(o_mode),
      .o_vol(o_vol),
      .o_fifo_level(o_fifo_level),
      .o_sdi_byte_cnt(o_sdi_byte_cnt),
      .o_err(o_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_sci_wr === 1'b1) begin
         wr_pulses++;
         last_wr_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      logic [15:0] exp_rd;
      logic [15:0] exp_mode;
   } sci_vec_t;

   sci_vec_t vecs [6];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One SCI frame of nbits bits; o_SO is captured just before each data-phase rising edge.
   task automatic applyStimulus(input logic [7:0] op, input logic [7:0] addr,
                                input logic [15:0] data, input int nbits,
                                output logic [15:0] rdata);
      logic [31:0] frame;
      frame = {op, addr, data};
      rdata = 16'h0000;
      bus.i_XCS = 1'b0;
      wait_clk(5);
      for (int i = 0; i < nbits; i++) begin
         bus.i_SI = frame[31-i];
         wait_clk(5);
         if (i >= 16) rdata[31-i] = bus.o_SO;
         bus.i_SCK = 1'b1;
         wait_clk(5);
         bus.i_SCK = 1'b0;
      end
      wait_clk(5);
      bus.i_XCS = 1'b1;
      bus.i_SI  = 1'b0;
      wait_clk(5);
   endtask

   task automatic sdi_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_SI = b[7-i];
         wait_clk(5);
         bus.i_SCK = 1'b1;
         wait_clk(5);
         bus.i_SCK = 1'b0;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
   endtask

   initial begin
      logic [15:0] rd;
      int          p0;
      int          n;

      vecs[0] = '{addr: 8'h01, data: 16'h1234, exp_rd: 16'h1234, exp_mode: 16'h0800};
      vecs[1] = '{addr: 8'h0B, data: 16'h2020, exp_rd: 16'h2020, exp_mode: 16'h0800};
      vecs[2] = '{addr: 8'h05, data: 16'hA5C3, exp_rd: 16'hA5C3, exp_mode: 16'h0800};
      vecs[3] = '{addr: 8'h0F, data: 16'hFFFF, exp_rd: 16'hFFFF, exp_mode: 16'h0800};
      vecs[4] = '{addr: 8'h00, data: 16'h4801, exp_rd: 16'h4801, exp_mode: 16'h4801};
      vecs[5] = '{addr: 8'h00, data: 16'h0800, exp_rd: 16'h0800, exp_mode: 16'h0800};

      rst        = 1'b1;
      bus.i_XCS  = 1'b1;
      bus.i_XDCS = 1'b1;
      bus.i_SCK  = 1'b0;
      bus.i_SI   = 1'b0;
      bus.i_XRST = 1'b1;
      wait_clk(4);

      checkOutput("rst_so",    bus.o_SO, 0);
      checkOutput("rst_dreq",  bus.o_DREQ, 0);
      checkOutput("rst_wr",    o_sci_wr, 0);
      checkOutput("rst_addr",  o_sci_addr, 0);
      checkOutput("rst_data",  o_sci_data, 0);
      checkOutput("rst_mode",  o_mode, 16'h0800);
      checkOutput("rst_vol",   o_vol, 0);
      checkOutput("rst_level", o_fifo_level, 0);
      checkOutput("rst_cnt",   o_sdi_byte_cnt, 0);
      checkOutput("rst_err",   o_err, 0);

      rst = 1'b0;
      wait_clk(1);
      checkOutput("dreq_after_rst", bus.o_DREQ, 1);
      wait_clk(4);

      $display("[TB] SCI write/read-back table");
      for (int i = 0; i < 6; i++) begin
         p0 = wr_pulses;
         applyStimulus(8'h02, vecs[i].addr, vecs[i].data, 32, rd);
         checkOutput("tbl_wr_pulse", wr_pulses - p0, 1);
         checkOutput("tbl_sci_addr", o_sci_addr, vecs[i].addr[3:0]);
         checkOutput("tbl_sci_data", o_sci_data, vecs[i].data);
         applyStimulus(8'h03, vecs[i].addr, 16'h0000, 32, rd);
         checkOutput("tbl_readback", rd, vecs[i].exp_rd);
         checkOutput("tbl_mode", o_mode, vecs[i].exp_mode);
      end
      checkOutput("tbl_vol", o_vol, 16'h2020);
      checkOutput("tbl_err", o_err, 0);

      $display("[TB] soft reset via SCI_MODE bit 2");
      p0 = wr_pulses;
      applyStimulus(8'h02, 8'h00, 16'h0804, 32, rd);
      checkOutput("srst_wr_pulse", wr_pulses - p0, 1);
      checkOutput("srst_sci_addr", o_sci_addr, 0);
      checkOutput("srst_sci_data", o_sci_data, 16'h0804);
      checkOutput("srst_mode", o_mode, 16'h0800);
      checkOutput("srst_dreq_low", bus.o_DREQ, 0);
      n = 0;
      while (n < 300 && bus.o_DREQ !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      checkOutput("srst_dreq_back", bus.o_DREQ, 1);
      checkOutput("srst_hold_len_ok",
                  ((cyc - last_wr_cyc) >= 100 && (cyc - last_wr_cyc) <= 102) ? 1 : 0, 1);

      $display("[TB] aborted SCI frame");
      p0 = wr_pulses;
      applyStimulus(8'h02, 8'h01, 16'hBEEF, 20, rd);
      checkOutput("abort_no_pulse", wr_pulses - p0, 0);
      applyStimulus(8'h03, 8'h01, 16'h0000, 32, rd);
      checkOutput("abort_reg_kept", rd, 16'h1234);
      checkOutput("abort_err", o_err, 0);
      p0 = wr_pulses;
      applyStimulus(8'h02, 8'h01, 16'h5555, 32, rd);
      checkOutput("after_abort_pulse", wr_pulses - p0, 1);
      applyStimulus(8'h03, 8'h01, 16'h0000, 32, rd);
      checkOutput("after_abort_read", rd, 16'h5555);

      $display("[TB] SDI stream and DREQ threshold");
      bus.i_XDCS = 1'b0;
      wait_clk(5);
      for (int k = 1; k <= 40; k++) begin
         sdi_bits(8'(k - 1), 8);
         checkOutput("sdi_level", o_fifo_level, 7'(k));
         checkOutput("sdi_dreq", bus.o_DREQ, (k <= 32) ? 1 : 0);
      end
      checkOutput("sdi_cnt_40", o_sdi_byte_cnt, 40);
      for (int k = 41; k <= 64; k++) sdi_bits(8'(k - 1), 8);
      checkOutput("full_level", o_fifo_level, 64);
      checkOutput("full_cnt", o_sdi_byte_cnt, 64);
      checkOutput("full_err", o_err, 0);
      sdi_bits(8'h40, 8);
      checkOutput("ovf_level", o_fifo_level, 64);
      checkOutput("ovf_cnt", o_sdi_byte_cnt, 64);
      checkOutput("ovf_err", o_err, 1);
      bus.i_XDCS = 1'b1;
      wait_clk(5);

      n = 0;
      while (n < 25000 && o_fifo_level == 7'd64) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_level", o_fifo_level, 63);
      checkOutput("drain_dreq", bus.o_DREQ, 0);

      $display("[TB] hardware reset mid-byte");
      bus.i_XDCS = 1'b0;
      wait_clk(5);
      sdi_bits(8'hF0, 4);
      bus.i_XRST = 1'b0;
      wait_clk(6);
      checkOutput("xrst_level", o_fifo_level, 0);
      checkOutput("xrst_cnt", o_sdi_byte_cnt, 0);
      checkOutput("xrst_mode", o_mode, 16'h0800);
      checkOutput("xrst_vol", o_vol, 0);
      checkOutput("xrst_err", o_err, 0);
      checkOutput("xrst_dreq_low", bus.o_DREQ, 0);
      bus.i_XRST = 1'b1;
      wait_clk(4);
      checkOutput("xrst_dreq_high", bus.o_DREQ, 1);
      sdi_bits(8'hF0, 4);
      checkOutput("xrst_partial_gone", o_fifo_level, 0);
      sdi_bits(8'hA0, 4);
      checkOutput("xrst_full_byte", o_fifo_level, 1);
      bus.i_XDCS = 1'b1;
      wait_clk(5);

      $display("[TB] SCI address out of range");
      p0 = wr_pulses;
      applyStimulus(8'h02, 8'h10, 16'h1111, 32, rd);
      checkOutput("addr16_no_pulse", wr_pulses - p0, 0);
      checkOutput("addr16_err", o_err, 1);
      checkOutput("addr16_mode", o_mode, 16'h0800);
      checkOutput("addr16_sci_data", o_sci_data, 0);

      $display("[TB] bus conflict");
      pulse_rst();
      checkOutput("conf_err_before", o_err, 0);
      p0 = wr_pulses;
      bus.i_XCS  = 1'b0;
      bus.i_XDCS = 1'b0;
      wait_clk(5);
      sdi_bits(8'hAA, 8);
      bus.i_XCS  = 1'b1;
      bus.i_XDCS = 1'b1;
      wait_clk(5);
      checkOutput("conf_err", o_err, 1);
      checkOutput("conf_level", o_fifo_level, 0);
      checkOutput("conf_cnt", o_sdi_byte_cnt, 0);
      checkOutput("conf_no_pulse", wr_pulses - p0, 0);

      $display("[TB] unknown opcode");
      pulse_rst();
      checkOutput("badop_err_before", o_err, 0);
      p0 = wr_pulses;
      applyStimulus(8'h05, 8'h0B, 16'h7777, 32, rd);
      checkOutput("badop_err", o_err, 1);
      checkOutput("badop_no_pulse", wr_pulses - p0, 0);
      checkOutput("badop_vol", o_vol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vs_codec_responder.md
Name: vs_codec_responder

Overview:
- Synthesizable responder model of the VS10xx-style audio decoder's serial side.
- Sits opposite the MP3 SPI master and answers on the same wires: SCI command port (i_XCS), SDI data port (i_XDCS), i_SCK, i_SI, i_XRST, o_SO, o_DREQ.
- Used in board-less loopback and simulation. It decodes SCI reads and writes into a 16x16 register file, buffers SDI bytes in a FIFO that drains at a fixed rate, and generates DREQ flow control.

Parameters:
FIFO_DEPTH, 64, SDI byte FIFO depth (power of 2)
DREQ_FREE, 32, minimum free FIFO bytes for o_DREQ=1
DRAIN_DIV, 200, clk cycles per byte consumed from the FIFO (models decoding)
SOFT_RST_CYCLES, 100, cycles o_DREQ is held low after a soft reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_XCS  in  1  SCI chip select, active low
i_XDCS  in  1  SDI chip select, active low
i_SCK  in  1  serial clock from master (asynchronous, ≤ clk/4)
i_SI  in  1  serial data in, MSB first
i_XRST  in  1  hardware reset from master, active low
o_SO  out  1  SCI read data
o_DREQ  out  1  data request / ready
o_sci_wr  out  1  one-cycle pulse on a completed SCI write
o_sci_addr  out  4  address of the last SCI write
o_sci_data  out  16  data of the last SCI write
o_mode  out  16  register 0x0 (SCI_MODE)
o_vol  out  16  register 0xB (SCI_VOL)
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_sdi_byte_cnt  out  32  total SDI bytes accepted
o_err  out  1  sticky protocol error

Behaviour:
Reset:
- rst=1 or synced i_XRST=0 resets everything.
- o_SO=0, o_DREQ=0, o_sci_wr=0, o_sci_addr=0, o_sci_data=0, o_err=0, FIFO empty, byte count 0.
- Registers reset to 0, except SCI_MODE=16'h0800.
- o_DREQ rises 1 clk after leaving reset.

Input synchronization and sampling:
- i_SCK, i_SI, i_XCS, i_XDCS and i_XRST pass through 2-flop synchronizers.
- A rising edge of synced SCK samples synced SI. A falling edge updates o_SO.

SCI state machine (IDLE, OPC, ADDR, DATA_WR, DATA_RD, DONE):
- Synced i_XCS falling enters OPC and clears the bit counter.
- After 8 bits, the opcode is latched and the state moves to ADDR.
- After 16 bits, the address is latched:
  - Opcode 8'h02 goes to DATA_WR.
  - Opcode 8'h03 goes to DATA_RD and loads the register shift-out value.
  - Any other opcode sets o_err; remaining bits are ignored until XCS rises.
- DATA_WR, 32nd bit: reg[addr[3:0]] is written. o_sci_addr and o_sci_data are updated and o_sci_wr pulses, 3 clk after the SCK edge. Then go to DONE.
  - Address ≥16: no register write and no o_sci_wr pulse; o_err is set.
- DATA_RD: o_SO drives register bits MSB first on SCK falling edges. o_SO=0 elsewhere.
- XCS rising from any state returns to IDLE. If fewer than 32 bits were seen, the frame is aborted silently: no write, no error.
- Extra bits after 32 are ignored.

Soft reset:
- Writing SCI_MODE with bit 2 set flushes the FIFO and holds o_DREQ=0 for SOFT_RST_CYCLES.
- Bit 2 self-clears in the stored register. All other bits keep the written value.

SDI path:
- While XDCS is low, bits shift in MSB first. Every 8th bit pushes one byte and increments o_sdi_byte_cnt.
- XDCS rising discards any partial byte.
- Push when the FIFO is full: the byte is dropped, the count is not incremented, and o_err is set.

Drain:
- When the FIFO is non-empty, one byte is popped every DRAIN_DIV clk.
- A push and a pop in the same cycle leave the level unchanged.

DREQ:
- o_DREQ = (FIFO_DEPTH − level ≥ DREQ_FREE) and not in the soft-reset hold. Registered, 1 clk latency.

Bus conflicts:
- XCS and XDCS both low sets o_err. The SCI and SDI shifters both ignore bits until one select deasserts.
- o_err clears only on reset.

Test Plan:
- SCI write 02_00_0804 (mode with soft reset bit) → o_sci_wr once with addr=0, data=16'h0804. o_mode=16'h0800. o_DREQ low for 100 clk, then high.
- SCI write 02_0B_2020, then read 03_0B → o_vol=16'h2020; o_SO returns 16'h2020 MSB first.
- Stream 40 SDI bytes 8'h00..8'h27 with DRAIN_DIV large → o_DREQ falls once the level reaches 33. o_sdi_byte_cnt=40.
- Keep pushing past 64 bytes → the 65th byte is dropped, o_err=1, level=64, count=64.
- Raise XCS after 20 bits of a write → no o_sci_wr, registers unchanged, o_err=0. Next full write succeeds.
- Pulse i_XRST low mid-SDI-byte → FIFO empty, SCI_MODE=16'h0800, o_DREQ=1 one clk after release. A full 8-bit byte is required for the next push.
